pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//   Parametrised pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
//   Next generation of the dff*/dffe* stage flops: width-generic, stall-aware, flushable.
//   Sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Gives full throughput with no combinational path from out_ready to in_ready.
// PARAMETERS
//   WIDTH          32  payload width in bits (>=1)
//   RESET_VAL      0   value loaded into both data registers on reset (WIDTH bits)
//   FLUSH_DATA_CLR 0   1: flush also loads RESET_VAL into data regs; 0: flush leaves data regs unchanged
// PORTS
//   clk        in   1      clock, all state updates on posedge
//   rst        in   1      synchronous reset, active-high
//   flush      in   1      synchronous pipeline flush (branch/exception kill)
//   in_valid   in   1      upstream payload valid
//   in_ready   out  1      stage can accept; transfer when in_valid && in_ready
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      out_data holds a valid payload
//   out_ready  in   1      downstream accepts; transfer when out_valid && out_ready
//   out_data   out  WIDTH  payload to next stage (main register)
//   occupancy  out  2      entries held: 0, 1 or 2
// BEHAVIOUR
//   Storage: main reg (drives out_data), skid reg (overflow), 2-bit state EMPTY/ONE/TWO.
//   Reset (rst=1 at posedge): state=EMPTY, main=skid=RESET_VAL; out_valid=0, occupancy=0.
//     in_ready=0 while rst is high; input and output transfers ignored that cycle.
//   Priority: rst > flush > normal operation.
//   Derived: out_valid=(state!=EMPTY); occupancy=state; in_ready=!rst && !flush && (state!=TWO).
//     in_ready depends only on registered state, rst and flush -- never on out_ready.
//   Let IN = in_valid&&in_ready, OUT = out_valid&&out_ready. Transitions:
//     EMPTY: IN -> ONE, main<=in_data. else stay.
//     ONE:   IN&OUT -> ONE, main<=in_data.  IN only -> TWO, skid<=in_data.
//            OUT only -> EMPTY.  neither -> stay.
//     TWO:   (IN impossible) OUT -> ONE, main<=skid.  else stay.
//   Latency: payload accepted at edge N is on out_data with out_valid=1 after edge N (1 cycle).
//   Throughput: 1 transfer/cycle sustained while out_ready=1.
//   Ordering: strict FIFO; no loss, no duplication; skid entry always older than any new input.
//   Backpressure: in_ready falls the cycle after skid fills (state TWO); rises after one OUT.
//   Flush (flush=1, rst=0): state<=EMPTY next edge; in_ready forced 0 so the concurrent input
//     is never captured; concurrent OUT still counts as a downstream transfer (payload consumed).
//     Data regs per FLUSH_DATA_CLR.
//   Reset/flush mid-operation: held entries discarded; no partial payload survives.
//   out_data is don't-care when out_valid=0 except immediately after reset (=RESET_VAL).
//   Stable output: out_data/out_valid change only on clk edge; unchanged while out_valid && !out_ready.
// TESTING
//   T1 reset: rst=1 2 cycles, in_valid=1, in_data=0xDEAD -> in_ready=0, out_valid=0,
//      occupancy=0, out_data=RESET_VAL; after rst=0 in_ready=1, nothing captured.
//   T2 stream: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data shows
//      0x11,0x22,0x33 one cycle later each, out_valid=1 three cycles, in_ready stays 1.
//   T3 backpressure: out_ready=0, push 0xA,0xB -> occupancy=2, in_ready=0; source holds 0xC;
//      then out_ready=1 -> outputs 0xA,0xB,0xC in order, no duplicate, in_ready back to 1.
//   T4 simultaneous: state ONE holding 0x5, in 0x6 with out_ready=1 -> next cycle
//      out_data=0x6, occupancy=1, 0x5 consumed exactly once.
//   T5 flush in TWO: hold 0x1,0x2, assert flush with in_valid=1, in_data=0x3 -> next cycle
//      occupancy=0, out_valid=0; 0x3 never appears; next push 0x4 emerges normally.
//   T6 reset mid-stream (WIDTH=8, RESET_VAL=0x5A): rst during T3 backpressure -> occupancy=0,
//      out_data=0x5A; resumed traffic delivered in order with no stale entries.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and 2-entry skid.
// Ports: clk, rst (sync, active-high), flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data (main reg), occupancy (0..2).
module pipe_skid_reg #(
  parameter int unsigned         WIDTH          = 32,
  parameter logic [WIDTH-1:0]    RESET_VAL      = '0,
  parameter bit                  FLUSH_DATA_CLR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             push;
  logic             pop;

  // in_ready is a function of registered state only (plus rst/flush),
  // so out_ready never reaches it combinationally.
  assign in_ready  = !rst && !flush && (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // A concurrent pop is still a completed transfer; held
      // entries are simply dropped.
      state_d = EMPTY;
      if (FLUSH_DATA_CLR) begin
        main_d = RESET_VAL;
        skid_d = RESET_VAL;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          unique case (1'b1)
            push && pop: begin
              main_d = in_data;
            end
            push && !pop: begin
              state_d = TWO;
              skid_d  = in_data;
            end
            !push && pop: begin
              state_d = EMPTY;
            end
            default: begin
              state_d = ONE;
            end
          endcase
        end
        TWO: begin
          // Skid entry is older than anything still upstream.
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg (WIDTH=8, RESET_VAL=0x5A).
// Queue-based reference model plus directed scenarios and random traffic.
module tb_pipe_skid_reg;

  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'h5A;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] got[$];
  logic [W-1:0] exp_log[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .WIDTH(W),
    .RESET_VAL(RV),
    .FLUSH_DATA_CLR(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .occupancy(occupancy)
  );

  // Advance one clock; log DUT deliveries and update the queue model.
  task automatic tick();
    bit           dpop;
    logic [W-1:0] dd;
    bit           mrdy;
    bit           mpop;
    bit           mpush;
    dpop  = out_valid && out_ready && !rst;
    dd    = out_data;
    mrdy  = !rst && !flush && (mq.size() < 2);
    mpop  = !rst && (mq.size() > 0) && out_ready;
    mpush = in_valid && mrdy;
    @(posedge clk);
    if (dpop === 1'b1) got.push_back(dd);
    if (mpop) exp_log.push_back(mq[0]);
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (mpop) void'(mq.pop_front());
      if (mpush) mq.push_back(in_data);
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; in_valid = 1; in_data = 8'hAD; out_ready = 1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready);
    end
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== RV) begin
      n_bad++;
      $display("FAIL rst_state got v=%b occ=%0d d=%h want v=0 occ=0 d=%h",
               out_valid, occupancy, out_data, RV);
    end
    rst = 0; in_valid = 0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_release_ready got=%b want=1", in_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_nothing_captured got v=%b occ=%0d want v=0 occ=0",
               out_valid, occupancy);
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] v[3];
    v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33;
    idle(); got.delete(); out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = v[i];
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++; $display("FAIL stream_ready[%0d] got=%b want=1", i, in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== v[i] || occupancy !== 2'd1) begin
        n_bad++;
        $display("FAIL stream_out[%0d] got v=%b d=%h occ=%0d want v=1 d=%h occ=1",
                 i, out_valid, out_data, occupancy, v[i]);
      end
    end
    in_valid = 0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || got.size() != 3) begin
      n_bad++;
      $display("FAIL stream_drain got v=%b n=%0d want v=0 n=3",
               out_valid, got.size());
    end
  endtask

  task automatic test_backpressure();
    idle(); got.delete();
    in_valid = 1; in_data = 8'h0A; tick();
    in_data = 8'h0B; tick();
    in_data = 8'h0C;
    #1;
    n_cmp++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 8'h0A) begin
      n_bad++;
      $display("FAIL bp_full got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=0a",
               occupancy, in_ready, out_data);
    end
    tick();
    n_cmp++;
    if (occupancy !== 2'd2 || out_data !== 8'h0A) begin
      n_bad++;
      $display("FAIL bp_hold got occ=%0d d=%h want occ=2 d=0a",
               occupancy, out_data);
    end
    out_ready = 1;
    tick();
    n_cmp++;
    if (out_data !== 8'h0B || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release got d=%h occ=%0d rdy=%b want d=0b occ=1 rdy=1",
               out_data, occupancy, in_ready);
    end
    tick();
    in_valid = 0;
    tick();
    tick();
    n_cmp++;
    if (got.size() != 3 || got[0] !== 8'h0A || got[1] !== 8'h0B ||
        got[2] !== 8'h0C || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_order got n=%0d seq=%p v=%b want seq=0a,0b,0c v=0",
               got.size(), got, out_valid);
    end
  endtask

  task automatic test_simultaneous();
    int n5;
    idle(); got.delete();
    in_valid = 1; in_data = 8'h05; tick();
    out_ready = 1; in_data = 8'h06; tick();
    in_valid = 0;
    n_cmp++;
    if (out_data !== 8'h06 || occupancy !== 2'd1) begin
      n_bad++;
      $display("FAIL simul_out got d=%h occ=%0d want d=06 occ=1",
               out_data, occupancy);
    end
    tick();
    tick();
    n5 = 0;
    foreach (got[i]) if (got[i] === 8'h05) n5++;
    n_cmp++;
    if (n5 != 1 || got.size() != 2) begin
      n_bad++;
      $display("FAIL simul_once got n05=%0d n=%0d want n05=1 n=2",
               n5, got.size());
    end
  endtask

  task automatic test_flush();
    int n3;
    idle(); got.delete();
    in_valid = 1; in_data = 8'h01; tick();
    in_data = 8'h02; tick();
    flush = 1; in_data = 8'h03;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL flush_ready got=%b want=0", in_ready);
    end
    tick();
    flush = 0; in_valid = 0;
    n_cmp++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_empty got occ=%0d v=%b want occ=0 v=0",
               occupancy, out_valid);
    end
    in_valid = 1; in_data = 8'h04; out_ready = 1; tick();
    in_valid = 0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h04) begin
      n_bad++;
      $display("FAIL flush_resume got v=%b d=%h want v=1 d=04",
               out_valid, out_data);
    end
    tick(); tick();
    n3 = 0;
    foreach (got[i]) if (got[i] === 8'h03) n3++;
    n_cmp++;
    if (n3 != 0 || got.size() != 1) begin
      n_bad++;
      $display("FAIL flush_no_kill got n03=%0d n=%0d want n03=0 n=1",
               n3, got.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] v[3];
    v[0] = 8'h71; v[1] = 8'h72; v[2] = 8'h73;
    idle(); got.delete();
    in_valid = 1; in_data = 8'h0A; tick();
    in_data = 8'h0B; tick();
    rst = 1; in_data = 8'h0C; tick();
    rst = 0; in_valid = 0;
    n_cmp++;
    if (occupancy !== 2'd0 || out_data !== RV || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_state got occ=%0d d=%h v=%b want occ=0 d=%h v=0",
               occupancy, out_data, out_valid, RV);
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = v[i]; tick();
    end
    in_valid = 0;
    tick(); tick();
    n_cmp++;
    if (got.size() != 3 || got[0] !== v[0] || got[1] !== v[1] ||
        got[2] !== v[2]) begin
      n_bad++;
      $display("FAIL rstmid_order got seq=%p want seq=71,72,73", got);
    end
  endtask

  task automatic test_random();
    int bad0;
    idle(); got.delete(); exp_log.delete();
    bad0 = n_bad;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      n_cmp++;
      if (in_ready !== (!flush && mq.size() < 2) ||
          out_valid !== (mq.size() > 0) ||
          occupancy !== 2'(mq.size()) ||
          (mq.size() > 0 && out_data !== mq[0])) begin
        n_bad++;
        if (n_bad - bad0 < 10)
          $display("FAIL rand[%0d] got rdy=%b v=%b occ=%0d d=%h want occ=%0d d=%h",
                   c, in_ready, out_valid, occupancy, out_data,
                   mq.size(), (mq.size() > 0) ? mq[0] : 8'h00);
      end
      tick();
    end
    idle(); out_ready = 1;
    tick(); tick(); tick();
    n_cmp++;
    if (got != exp_log) begin
      n_bad++;
      $display("FAIL rand_order got n=%0d want n=%0d", got.size(), exp_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
